// File: rtl/regf_pkg.sv
// Shared defaults, index-width helper and word/index types for the register file.
package regf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int regf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

  typedef logic [regf_aw(NREGS_DEF)-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0]           word_t;
endpackage

// File: rtl/regf_sb_if.sv
// Decode/writeback bundle of the register file: reads, issue, writeback, pending count.
interface regf_sb_if
  import regf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = regf_aw(NREGS);

  logic [NRD-1:0]      i_rd_en;
  logic [NRD*AW-1:0]   i_rd_reg;
  logic [NRD*XLEN-1:0] o_rd_val;
  logic [NRD-1:0]      o_rd_busy;
  logic                o_stall;
  logic                i_iss_en;
  logic [AW-1:0]       i_iss_reg;
  logic                i_wb_en;
  logic [AW-1:0]       i_wb_reg;
  logic [XLEN-1:0]     i_wb_val;
  logic [AW:0]         o_pend_cnt;

  modport master (
    output i_rd_en, i_rd_reg, i_iss_en, i_iss_reg, i_wb_en, i_wb_reg, i_wb_val,
    input  o_rd_val, o_rd_busy, o_stall, o_pend_cnt
  );
  modport slave (
    input  i_rd_en, i_rd_reg, i_iss_en, i_iss_reg, i_wb_en, i_wb_reg, i_wb_val,
    output o_rd_val, o_rd_busy, o_stall, o_pend_cnt
  );
endinterface

// File: rtl/regf_scbd.sv
// Busy scoreboard: per-register pending bits, per-port hazard lookup, in-flight count.
module regf_scbd
  import regf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = regf_aw(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD-1:0][AW-1:0]  rd_reg,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_reg,
  input  logic                    wb_en,
  input  logic [AW-1:0]           wb_reg,
  output logic [NRD-1:0]          rd_busy,
  output logic                    stall,
  output logic [AW:0]             pend_cnt
);
  logic [NREGS-1:0] busy_q, busy_nxt;
  logic             set_tr, clr_tr;

  // Issue is applied after writeback so the newer producer wins on a collision.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_en)  busy_nxt[wb_reg]  = 1'b0;
    if (iss_en) busy_nxt[iss_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Count follows real bit transitions only, so it can never drift from busy_q.
  assign set_tr = iss_en && (iss_reg != '0) && !busy_q[iss_reg];
  assign clr_tr = wb_en && (wb_reg != '0) && busy_q[wb_reg] &&
                  !(iss_en && (iss_reg == wb_reg));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q   <= '0;
      pend_cnt <= '0;
    end else begin
      busy_q <= busy_nxt;
      case ({set_tr, clr_tr})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    assign rd_busy[k] = busy_q[rd_reg[k]] & ~(wb_en & (wb_reg == rd_reg[k]));
  end

  assign stall = |(rd_en & rd_busy);
endmodule

// File: rtl/regf_sb.sv
// Register file with r0 hardwired to zero, write-to-read bypass and integrated scoreboard.
module regf_sb
  import regf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  regf_sb_if.slave    bus
);
  localparam int AW = regf_aw(NREGS);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (bus.i_wb_en && (bus.i_wb_reg != '0)) begin
      mem[bus.i_wb_reg] <= bus.i_wb_val;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.i_rd_reg[k*AW +: AW];
    assign bus.o_rd_val[k*XLEN +: XLEN] =
      (ra == '0)                              ? '0 :
      (bus.i_wb_en && (bus.i_wb_reg == ra))   ? bus.i_wb_val :
                                                mem[ra];
  end

  regf_scbd #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_scbd (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .rd_en    (bus.i_rd_en),
    .rd_reg   (bus.i_rd_reg),
    .iss_en   (bus.i_iss_en),
    .iss_reg  (bus.i_iss_reg),
    .wb_en    (bus.i_wb_en),
    .wb_reg   (bus.i_wb_reg),
    .rd_busy  (bus.o_rd_busy),
    .stall    (bus.o_stall),
    .pend_cnt (bus.o_pend_cnt)
  );
endmodule
